mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter W SHALL default to 8 and set the operand width.
REQ-002 Parameter TMO SHALL default to 2*W+4 and set the WAIT-state timeout in cycles.
REQ-003 Ports SHALL be as follows:
- Clk  in  1  single clock, all state on rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Req0, Req1  in  1  multiply request from requester 0/1.
- A0, B0, A1, B1  in  W  multiplicand/multiplier of requester 0/1.
- Gnt0, Gnt1  out  1  operands captured, one-cycle pulse.
- Rdy0, Rdy1  out  1  result valid on P, one-cycle pulse.
- Err  out  1  timeout abort, qualifies Rdy0/Rdy1.
- P  out  2W  product returned to requesters.
- Busy  out  1  arbiter not in IDLE.
- St  out  1  start pulse to multiplier control.
- Mcand, Mplier  out  W  operands to multiplier datapath.
- Idle, Done  in  1  status from multiplier control.
- Prod  in  2W  multiplier product.

Function
REQ-004 FSM states SHALL be IDLE, START, WAIT, DONE; all outputs SHALL be Moore, decoded from registered state and owner.
REQ-005 IDLE SHALL arbitrate only when Idle=1 and Req0|Req1=1; otherwise it SHALL stay in IDLE.
REQ-006 Single request SHALL be granted to that requester regardless of pointer.
REQ-007 Simultaneous requests SHALL be resolved by round-robin: if Last=0, grant 1; if Last=1, grant 0.
REQ-008 On the arbitration edge, the owner's A/B SHALL be latched into Mcand/Mplier, owner recorded, state set to START.
REQ-009 Mcand/Mplier SHALL hold stable from START until the next arbitration.
REQ-010 START SHALL last exactly one cycle: St=1, Gnt(owner)=1, then go to WAIT.
REQ-011 WAIT SHALL clear, then increment, a timeout counter each cycle.
REQ-012 On Done=1 in WAIT, Prod SHALL be latched into P, Err set to 0, state set to DONE.
REQ-013 If the counter reaches TMO-1 without Done, P SHALL be set to 0, Err set to 1, state set to DONE.
REQ-014 Done and timeout in the same cycle SHALL resolve in favour of Done.
REQ-015 DONE SHALL last one cycle: Rdy(owner)=1 and Err valid; Last set to owner; then go to IDLE.
REQ-016 P SHALL hold its value until the next latch.
REQ-017 Err SHALL be meaningful only while Rdy0 or Rdy1=1 and SHALL be 0 in IDLE and START.
REQ-018 Req SHALL be sampled only in IDLE; requesters drop Req after Gnt, and a Req still high when IDLE is re-entered SHALL be a new request.
REQ-019 Busy SHALL be 1 in START, WAIT and DONE.
REQ-020 Minimum latency SHALL be: Req in IDLE at edge n -> Gnt/St at n+1 -> Rdy one cycle after the Done cycle.
REQ-021 Gnt0/Gnt1 SHALL never be asserted together, and Rdy0/Rdy1 SHALL never be asserted together.

Reset
REQ-022 Reset_n=0 SHALL asynchronously force state=IDLE, Last=1, counter=0, owner=0.
REQ-023 Reset_n=0 SHALL asynchronously clear St, Gnt0/1, Rdy0/1, Err, Busy, P, Mcand, Mplier.
REQ-024 Reset mid-operation SHALL abandon the transaction with no Rdy pulse; multiplier reset is handled externally.
REQ-025 The first arbitration after reset SHALL favour requester 0 on a tie.

Verification
REQ-026 Single request: after reset, Req0=1, A0=13, B0=11, Idle=1 -> next cycle St=Gnt0=1, Mcand=13, Mplier=11; model Done at WAIT cycle 17 with Prod=143 -> Rdy0=1, P=143, Err=0, Busy falls after DONE.
REQ-027 Tie: after reset, Req0=Req1=1 with A0=3, B0=4, A1=5, B1=6 -> Gnt0 first, Rdy0 with P=12; Req1 held -> Gnt1 next, Rdy1 with P=30; no overlap of pulses.
REQ-028 Fairness: with Last=0 and both requesting -> requester 1 wins; with Req1 only repeated twice -> granted both times.
REQ-029 Timeout: W=8, TMO=20, Done held 0 -> exactly 20 WAIT cycles, then Rdy0=1, Err=1, P=0, IDLE.
REQ-030 Hold-off and reset: Idle=0 with Req0=1 -> no St for 10 cycles, then Idle=1 -> grant. Reset_n=0 in WAIT -> all outputs 0 immediately, no Rdy, next tie goes to requester 0.

Source files
------------

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester round-robin arbiter for a shared multiplier
module mult_arbiter #(
  parameter int W   = 8,
  parameter int TMO = 2*W+4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Req0,
  input  logic           Req1,
  input  logic [W-1:0]   A0,
  input  logic [W-1:0]   B0,
  input  logic [W-1:0]   A1,
  input  logic [W-1:0]   B1,
  output logic           Gnt0,
  output logic           Gnt1,
  output logic           Rdy0,
  output logic           Rdy1,
  output logic           Err,
  output logic [2*W-1:0] P,
  output logic           Busy,
  output logic           St,
  output logic [W-1:0]   Mcand,
  output logic [W-1:0]   Mplier,
  input  logic           Idle,
  input  logic           Done,
  input  logic [2*W-1:0] Prod
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic          owner;
  logic          last;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          arb_go;
  logic          arb_owner;
  logic          timeout;

  // A tie goes to whoever did not finish last; a lone request always wins.
  assign arb_go    = Idle & (Req0 | Req1);
  assign arb_owner = (Req0 & Req1) ? ~last : Req1;
  assign timeout   = (cnt == CW'(TMO - 1));

  // Moore outputs decoded from registered state and owner.
  assign St   = (state == S_START);
  assign Gnt0 = (state == S_START) & ~owner;
  assign Gnt1 = (state == S_START) &  owner;
  assign Rdy0 = (state == S_DONE)  & ~owner;
  assign Rdy1 = (state == S_DONE)  &  owner;
  assign Err  = (state == S_DONE)  &  err_q;
  assign Busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; Done takes priority over an expiring timeout.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (arb_go) state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT:  if (Done || timeout) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, timeout counter, result latch and round-robin pointer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      owner  <= 1'b0;
      last   <= 1'b1;
      err_q  <= 1'b0;
      cnt    <= '0;
      P      <= '0;
      Mcand  <= '0;
      Mplier <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_go) begin
            owner  <= arb_owner;
            Mcand  <= arb_owner ? A1 : A0;
            Mplier <= arb_owner ? B1 : B0;
          end
        end
        S_START: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (Done) begin
            P     <= Prod;
            err_q <= 1'b0;
          end else if (timeout) begin
            P     <= '0;
            err_q <= 1'b1;
          end
        end
        S_DONE: last <= owner;
        default: ;
      endcase
    end
  end

endmodule
